// File: rtl/mips_run_pkg.sv
// Shared encodings for the mips core run controller: FSM states, stop causes and the
// default halt instruction.
package mips_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST_HOLD = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } run_state_e;

  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_HALT_INSTR = 2'd1;
  localparam logic [1:0] CAUSE_PC_STUCK   = 2'd2;
  localparam logic [1:0] CAUSE_LIMIT      = 2'd3;

  // beq $0,$0,-1 : the core spins on itself
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h1000ffff;

endpackage

// File: rtl/mips_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable; sticks at all-ones.
module run_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: holds core reset after start, gates the core clock-enable
// in free-run or single-step mode, and stops on a halt instruction, a stuck PC or a cycle limit.
//
// state    | meaning
// ST_IDLE  | core held in reset, waiting for start
// ST_RST_HOLD | core reset held for RST_HOLD_CYCLES cycles
// ST_RUN   | core released; core_en per free-run or step mode, stop checks active
// ST_DONE  | core stopped, count and cause frozen, waiting for start
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 10,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned HALT_REPEAT     = 4,
  parameter logic [31:0] HALT_WORD       = DEFAULT_HALT_WORD
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             step_mode_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] max_cycles_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  output logic             core_reset_o,
  output logic             core_en_o,
  output logic             running_o,
  output logic             done_o,
  output logic [1:0]       done_cause_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  localparam int unsigned HOLD_W  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int unsigned STUCK_W = $clog2(HALT_REPEAT);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_HIT = STUCK_W'(HALT_REPEAT - 1);

  run_state_e         state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STUCK_W-1:0] stuck_q, stuck_d;
  logic [31:0]        pc_ref_q, pc_ref_d;
  logic               ref_vld_q, ref_vld_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [1:0]         cause_q, cause_d;
  logic               core_reset_q, core_reset_d;
  logic               core_en_q, core_en_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               step_q, step_d;

  logic               cnt_clr;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W:0]     cnt_inc;
  logic [STUCK_W-1:0] stuck_inc;
  logic               step_edge;
  logic               pc_same;
  logic               is_halt;
  logic               is_stuck;
  logic               is_limit;

  assign step_edge = step_i & ~step_q;
  assign pc_same   = ref_vld_q && (pc_i == pc_ref_q);
  assign stuck_inc = stuck_q + STUCK_W'(1);
  assign is_halt   = (instr_i == HALT_WORD);
  assign is_stuck  = pc_same && (stuck_inc == STUCK_HIT);
  assign cnt_inc   = {1'b0, cycle_count} + (CNT_W+1)'(1);
  assign is_limit  = (max_q != '0) && (cnt_inc == {1'b0, max_q});

  // Edge detector only tracks step inside RUN, so a step already high on entry is one edge.
  assign step_d = (state_q == ST_RUN) ? step_i : 1'b0;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stuck_d   = stuck_q;
    pc_ref_d  = pc_ref_q;
    ref_vld_d = ref_vld_q;
    max_d     = max_q;
    cause_d   = cause_q;
    core_en_d = 1'b0;
    cnt_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d   = ST_RST_HOLD;
          hold_d    = HOLD_LOAD;
          max_d     = max_cycles_i;
          cause_d   = CAUSE_NONE;
          stuck_d   = '0;
          ref_vld_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      ST_RST_HOLD: begin
        if (hold_q == '0) begin
          state_d   = ST_RUN;
          core_en_d = ~step_mode_i;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (core_en_q) begin
          pc_ref_d  = pc_i;
          ref_vld_d = 1'b1;
          stuck_d   = pc_same ? stuck_inc : '0;
          if (is_halt) begin
            cause_d = CAUSE_HALT_INSTR;
            state_d = ST_DONE;
          end else if (is_stuck) begin
            cause_d = CAUSE_PC_STUCK;
            state_d = ST_DONE;
          end else if (is_limit) begin
            cause_d = CAUSE_LIMIT;
            state_d = ST_DONE;
          end
        end
        if (state_d == ST_RUN) begin
          core_en_d = step_mode_i ? (step_edge & ~core_en_q) : 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_reset_d = (state_d == ST_IDLE) || (state_d == ST_RST_HOLD);
    running_d    = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      stuck_q      <= '0;
      pc_ref_q     <= '0;
      ref_vld_q    <= 1'b0;
      max_q        <= '0;
      cause_q      <= CAUSE_NONE;
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      stuck_q      <= stuck_d;
      pc_ref_q     <= pc_ref_d;
      ref_vld_q    <= ref_vld_d;
      max_q        <= max_d;
      cause_q      <= cause_d;
      core_reset_q <= core_reset_d;
      core_en_q    <= core_en_d;
      running_q    <= running_d;
      done_q       <= done_d;
      step_q       <= step_d;
    end
  end

  run_sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (cnt_clr),
    .en_i    (core_en_q),
    .count_o (cycle_count)
  );

  assign core_reset_o  = core_reset_q;
  assign core_en_o     = core_en_q;
  assign running_o     = running_q;
  assign done_o        = done_q;
  assign done_cause_o  = cause_q;
  assign cycle_count_o = cycle_count;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: reset hold, halt, stuck PC, limit, step mode, mid-run reset.
module tb_mips_run_ctrl;
  import mips_run_pkg::*;

  localparam logic [31:0] HALT = 32'h1000ffff;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        step_mode_i;
  logic        step_i;
  logic [31:0] max_cycles_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        core_reset_o;
  logic        core_en_o;
  logic        running_o;
  logic        done_o;
  logic [1:0]  done_cause_o;
  logic [31:0] cycle_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;
  int sn;
  int s_halt;

  mips_run_ctrl dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .step_mode_i   (step_mode_i),
    .step_i        (step_i),
    .max_cycles_i  (max_cycles_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .core_reset_o  (core_reset_o),
    .core_en_o     (core_en_o),
    .running_o     (running_o),
    .done_o        (done_o),
    .done_cause_o  (done_cause_o),
    .cycle_count_o (cycle_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] max, input logic mode);
    step_mode_i  = mode;
    max_cycles_i = max;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i      = 1'b0;
    max_cycles_i = '0;
  endtask

  // Plays the core: presents pc/instr for each enabled cycle until done or budget runs out.
  task automatic run_to_done(input int halt_at, input int stuck_from,
                             output int hold, output logic first_en, output logic first_run);
    int  n;
    int  cyc;
    bit  seen;
    n = 0; cyc = 0; seen = 0;
    hold = 0; first_en = 1'b0; first_run = 1'b0;
    while (!done_o && cyc < 500) begin
      if (core_reset_o) begin
        hold++;
      end else if (!seen) begin
        seen      = 1;
        first_en  = core_en_o;
        first_run = running_o;
      end
      if (core_en_o) begin
        n++;
        pc_i    = (stuck_from != 0 && n >= stuck_from) ? 32'h3000 : 32'(n * 4);
        instr_i = (n == halt_at) ? HALT : 32'h0;
      end
      @(negedge clk_i);
      cyc++;
    end
    check("run_reaches_done", done_o, 1);
  endtask

  task automatic check_stop(input logic [1:0] cause, input int cnt);
    check("done", done_o, 1);
    check("done_cause", done_cause_o, cause);
    check("cycle_count", cycle_count_o, cnt);
    check("core_en_off", core_en_o, 0);
    check("core_reset_off", core_reset_o, 0);
    check("running_off", running_o, 0);
    repeat (3) @(negedge clk_i);
    check("count_frozen", cycle_count_o, cnt);
    check("cause_frozen", done_cause_o, cause);
    check("core_en_stays_off", core_en_o, 0);
  endtask

  task automatic step_tick(input logic s);
    if (core_en_o) begin
      pulses++;
      sn++;
      pc_i    = 32'h100 + 32'(sn * 4);
      instr_i = (sn == s_halt) ? HALT : 32'h0;
    end
    step_i = s;
    @(negedge clk_i);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int   hold;
    logic first_en;
    logic first_run;
    int   cyc;
    int   n;

    reset_i = 1'b1; start_i = 1'b0; step_mode_i = 1'b0; step_i = 1'b0;
    max_cycles_i = '0; pc_i = '0; instr_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_core_reset", core_reset_o, 1);
    check("rst_core_en", core_en_o, 0);
    check("rst_running", running_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cause", done_cause_o, 0);
    check("rst_count", cycle_count_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("idle_no_start_reset", core_reset_o, 1);

    // free-run, halt on 7th enabled cycle
    do_start(32'd0, 1'b0);
    run_to_done(7, 0, hold, first_en, first_run);
    check("hold_cycles", hold, 10);
    check("first_run_en", first_en, 1);
    check("first_run_running", first_run, 1);
    check_stop(CAUSE_HALT_INSTR, 7);

    // pc stuck from the 5th enabled cycle
    do_start(32'd0, 1'b0);
    run_to_done(0, 5, hold, first_en, first_run);
    check("hold_cycles_2", hold, 10);
    check_stop(CAUSE_PC_STUCK, 8);

    // cycle limit
    do_start(32'd20, 1'b0);
    run_to_done(0, 0, hold, first_en, first_run);
    check_stop(CAUSE_LIMIT, 20);

    // restart in step mode with limit 5; halt also placed on the 5th step
    do_start(32'd5, 1'b1);
    check("restart_count_cleared", cycle_count_o, 0);
    check("restart_cause_cleared", done_cause_o, 0);
    check("restart_done_cleared", done_o, 0);
    pulses = 0; sn = 0; s_halt = 5;
    hold = 0; cyc = 0;
    while (core_reset_o && cyc < 50) begin
      hold++;
      step_tick(1'b0);
      cyc++;
    end
    check("rehold_cycles", hold, 10);
    repeat (3) step_tick(1'b0);
    check("step_idle_no_en", pulses, 0);
    step_tick(1'b1); repeat (4) step_tick(1'b0);
    step_tick(1'b1); step_tick(1'b0);
    start_i = 1'b1; step_tick(1'b0); start_i = 1'b0;
    step_tick(1'b0); step_tick(1'b0);
    check("start_ignored_running", running_o, 1);
    check("start_ignored_reset", core_reset_o, 0);
    repeat (10) step_tick(1'b1);
    repeat (3) step_tick(1'b0);
    check("step_pulses", pulses, 3);
    check("step_count", cycle_count_o, 3);
    step_tick(1'b1); repeat (4) step_tick(1'b0);
    check("step_count_4", cycle_count_o, 4);
    step_tick(1'b1); step_tick(1'b0); step_tick(1'b0);
    check("step_pulses_5", pulses, 5);
    check_stop(CAUSE_HALT_INSTR, 5);

    // reset asserted mid-run at cycle_count 12
    do_start(32'd0, 1'b0);
    n = 0; cyc = 0;
    while (cycle_count_o != 32'd12 && cyc < 100) begin
      if (core_en_o) begin
        n++;
        pc_i    = 32'h2000 + 32'(n * 4);
        instr_i = 32'h0;
      end
      @(negedge clk_i);
      cyc++;
    end
    check("midrun_count_12", cycle_count_o, 12);
    check("midrun_running", running_o, 1);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("midrst_core_reset", core_reset_o, 1);
    check("midrst_core_en", core_en_o, 0);
    check("midrst_running", running_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_cause", done_cause_o, 0);
    check("midrst_count", cycle_count_o, 0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("idle_after_reset", core_reset_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
